// File: rtl/led_ctrl_blink.sv
// led_ctrl_blink: bus-mapped LED controller with static levels and a shared
// blink cadence. Each LED is either a plain level from LED_VAL or, when its
// BLINK_MASK bit is set, gated by a common ON/OFF phase machine. The phase
// machine advances on ticks from a free-running clock prescaler.
//
// Register map (16-bit bus, Addr[1:0]):
//   0 LED_VAL     [NUM_LEDS-1:0] static level per LED
//   1 BLINK_MASK  [NUM_LEDS-1:0] 1 = LED follows the blink phase
//   2 BLINK_TIME  [7:0] ON ticks, [15:8] OFF ticks; any write restarts the cadence
//   3 STATUS      [15] phase_on, [7:0] ticks spent in the current phase
//
// Optional build macro LED_DIM_EN: Addr 3 becomes {phase_on, DUTY} with a
// writable PWM_BITS-wide DUTY. A free-running PWM counter dims all LEDs.
module led_ctrl_blink #(
  parameter int NUM_LEDS     = 6,
  parameter int PRESCALE_DIV = 50000,
  parameter int PRESCALE_W   = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          Addr,
  output logic [15:0]         DataRd,
  input  logic [15:0]         DataWr,
  input  logic                En,
  input  logic                Rd,
  input  logic                Wr,
  output logic [NUM_LEDS-1:0] Led
);

  typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} phase_e;

  localparam logic [PRESCALE_W-1:0] PSC_LAST = PRESCALE_W'(PRESCALE_DIV - 1);

  // Register file
  logic [NUM_LEDS-1:0]   r_led_val;
  logic [NUM_LEDS-1:0]   r_blink_mask;
  logic [7:0]            r_on_t;
  logic [7:0]            r_off_t;

  // Cadence state
  logic [PRESCALE_W-1:0] r_psc;
  phase_e                r_state;
  phase_e                w_state_nxt;
  logic [7:0]            r_pcnt;
  logic [7:0]            w_pcnt_nxt;

  logic                  w_wr;
  logic                  w_time_wr;
  logic                  w_tick;
  logic                  w_phase_on;
  logic                  w_dim_on;
  logic [8:0]            w_pcnt_inc;
  logic [NUM_LEDS-1:0]   w_led_nxt;
  logic [NUM_LEDS-1:0]   r_led;

  // Reads have no side effects, so the read strobe carries no information.
  logic                  w_unused_rd;
  assign w_unused_rd = Rd;

  assign w_wr       = Wr & En;
  assign w_time_wr  = w_wr & (Addr == 2'd2);
  assign w_tick     = (r_psc == PSC_LAST);
  assign w_pcnt_inc = {1'b0, r_pcnt} + 9'd1;

  // A zero ON time means the LEDs never light; a zero OFF time (with a
  // non-zero ON time) means they never go dark. Both zero resolves to OFF.
  assign w_phase_on = (r_on_t == 8'd0)  ? 1'b0 :
                      (r_off_t == 8'd0) ? 1'b1 :
                      (r_state == ST_ON);

  // Register writes; Reset takes priority over a simultaneous write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_led_val    <= '0;
      r_blink_mask <= '0;
      r_on_t       <= 8'd8;
      r_off_t      <= 8'd8;
    end else if (w_wr) begin
      case (Addr)
        2'd0: r_led_val    <= DataWr[NUM_LEDS-1:0];
        2'd1: r_blink_mask <= DataWr[NUM_LEDS-1:0];
        2'd2: begin
          r_on_t  <= DataWr[7:0];
          r_off_t <= DataWr[15:8];
        end
        default: ;
      endcase
    end
  end

  // Prescaler: wraps at PRESCALE_DIV-1, restarted by a BLINK_TIME write
  always_ff @(posedge Clk) begin
    if (Reset || w_time_wr) r_psc <= '0;
    else if (w_tick)        r_psc <= '0;
    else                    r_psc <= r_psc + 1'b1;
  end

  // Phase machine state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_ON;
      r_pcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  // Phase machine next state: restart, degenerate times, then tick-driven cadence
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    if (w_time_wr) begin
      w_state_nxt = ST_ON;
      w_pcnt_nxt  = 8'd0;
    end else if (r_on_t == 8'd0) begin
      w_state_nxt = ST_OFF;
      w_pcnt_nxt  = 8'd0;
    end else if (r_off_t == 8'd0) begin
      w_state_nxt = ST_ON;
      w_pcnt_nxt  = 8'd0;
    end else if (w_tick) begin
      case (r_state)
        ST_ON: begin
          if (w_pcnt_inc >= {1'b0, r_on_t}) begin
            w_state_nxt = ST_OFF;
            w_pcnt_nxt  = 8'd0;
          end else begin
            w_pcnt_nxt  = w_pcnt_inc[7:0];
          end
        end
        default: begin
          if (w_pcnt_inc >= {1'b0, r_off_t}) begin
            w_state_nxt = ST_ON;
            w_pcnt_nxt  = 8'd0;
          end else begin
            w_pcnt_nxt  = w_pcnt_inc[7:0];
          end
        end
      endcase
    end
  end

`ifdef LED_DIM_EN
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pwm;

  // DUTY register lives at Addr 3; reset to full brightness
  always_ff @(posedge Clk) begin
    if (Reset)                      r_duty <= '1;
    else if (w_wr && Addr == 2'd3)  r_duty <= DataWr[PWM_BITS-1:0];
  end

  // Free-running PWM counter, one step per clock
  always_ff @(posedge Clk) begin
    if (Reset) r_pwm <= '0;
    else       r_pwm <= r_pwm + 1'b1;
  end

  // All-ones duty is a true constant-on rather than (2^N-1)/2^N
  assign w_dim_on = (r_duty == '1) | (r_pwm < r_duty);
`else
  logic [PWM_BITS-1:0] w_unused_pwm;
  assign w_unused_pwm = '0;
  assign w_dim_on     = 1'b1;
`endif

  assign w_led_nxt = r_led_val & (~r_blink_mask | {NUM_LEDS{w_phase_on}})
                   & {NUM_LEDS{w_dim_on}};

  // LED drive register
  always_ff @(posedge Clk) begin
    if (Reset) r_led <= '0;
    else       r_led <= w_led_nxt;
  end

  assign Led = r_led;

  // Read mux: combinational from Addr, not gated by Rd/En
  always_comb begin
    DataRd = '0;
    case (Addr)
      2'd0: DataRd[NUM_LEDS-1:0] = r_led_val;
      2'd1: DataRd[NUM_LEDS-1:0] = r_blink_mask;
      2'd2: DataRd = {r_off_t, r_on_t};
      default: begin
        DataRd[15] = w_phase_on;
`ifdef LED_DIM_EN
        DataRd[PWM_BITS-1:0] = r_duty;
`else
        DataRd[7:0] = r_pcnt;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_led_ctrl_blink.sv
// Directed bench for led_ctrl_blink with PRESCALE_DIV=4 so blink cadences
// are short. Inputs change and outputs are sampled on the falling edge.
module tb_led_ctrl_blink;

  localparam int NL = 6;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [1:0]    Addr = '0;
  logic [15:0]   DataRd;
  logic [15:0]   DataWr = '0;
  logic          En = 1'b0;
  logic          Rd = 1'b0;
  logic          Wr = 1'b0;
  logic [NL-1:0] Led;

  int checks = 0;
  int errors = 0;

  led_ctrl_blink #(
    .NUM_LEDS(NL), .PRESCALE_DIV(4), .PRESCALE_W(16), .PWM_BITS(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
    .En(En), .Rd(Rd), .Wr(Wr), .Led(Led)
  );

  always #5 Clk = ~Clk;

  // One bus write; returns on the falling edge right after the write edge.
  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; Wr = 1'b1; En = 1'b1;
    @(negedge Clk);
    Wr = 1'b0; En = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    Addr = 2'd0; #1; checks++;
    if (DataRd !== 16'h0000) begin errors++; $display("FAIL rst_addr0 got %h exp %h", DataRd, 16'h0000); end
    Addr = 2'd1; #1; checks++;
    if (DataRd !== 16'h0000) begin errors++; $display("FAIL rst_addr1 got %h exp %h", DataRd, 16'h0000); end
    Addr = 2'd2; #1; checks++;
    if (DataRd !== 16'h0808) begin errors++; $display("FAIL rst_addr2 got %h exp %h", DataRd, 16'h0808); end
    Addr = 2'd3; #1; checks++;
    if (DataRd[15] !== 1'b1) begin errors++; $display("FAIL rst_phase got %b exp 1", DataRd[15]); end
    checks++;
    if (Led !== 6'b0) begin errors++; $display("FAIL rst_led got %b exp %b", Led, 6'b0); end
  endtask

  task automatic test_led_val;
    do_write(2'd0, 16'h0015);
    checks++;
    if (Led !== 6'b0) begin errors++; $display("FAIL led_early got %b exp %b", Led, 6'b0); end
    @(negedge Clk); checks++;
    if (Led !== 6'b010101) begin errors++; $display("FAIL led_val got %b exp %b", Led, 6'b010101); end
    Addr = 2'd0; #1; checks++;
    if (DataRd !== 16'h0015) begin errors++; $display("FAIL rb_15 got %h exp %h", DataRd, 16'h0015); end
    do_write(2'd0, 16'hFFFF);
    Addr = 2'd0; #1; checks++;
    if (DataRd !== 16'h003F) begin errors++; $display("FAIL rb_ffff got %h exp %h", DataRd, 16'h003F); end
    @(negedge Clk); checks++;
    if (Led !== 6'h3F) begin errors++; $display("FAIL led_all got %b exp %b", Led, 6'h3F); end
  endtask

  // ON_T=2, OFF_T=3 ticks of 4 clocks: 8 high, 12 low, starting one edge
  // after the restart edge.
  task automatic test_blink;
    logic exp;
    do_write(2'd0, 16'h0001);
    do_write(2'd1, 16'h0001);
    do_write(2'd2, 16'h0302);
    Addr = 2'd3;
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clk); #1;
      exp = (((j - 1) % 20) < 8);
      checks++;
      if (Led !== {5'b0, exp}) begin
        errors++; $display("FAIL blink_j%0d got %b exp %b", j, Led, {5'b0, exp});
      end
`ifndef LED_DIM_EN
      if (j == 5) begin
        checks++;
        if (DataRd !== 16'h8001) begin errors++; $display("FAIL status_on got %h exp %h", DataRd, 16'h8001); end
      end
      if (j == 10) begin
        checks++;
        if (DataRd !== 16'h0000) begin errors++; $display("FAIL status_off got %h exp %h", DataRd, 16'h0000); end
      end
`endif
    end
  endtask

  task automatic test_degenerate;
    do_write(2'd2, 16'h0003);
    for (int j = 0; j < 30; j++) begin
      @(negedge Clk); checks++;
      if (Led !== 6'b000001) begin errors++; $display("FAIL forced_on_j%0d got %b exp %b", j, Led, 6'b000001); end
    end
    Addr = 2'd3; #1; checks++;
    if (DataRd[15] !== 1'b1) begin errors++; $display("FAIL forced_on_ph got %b exp 1", DataRd[15]); end
    do_write(2'd2, 16'h0300);
    for (int j = 0; j < 30; j++) begin
      @(negedge Clk); checks++;
      if (Led !== 6'b000000) begin errors++; $display("FAIL forced_off_j%0d got %b exp %b", j, Led, 6'b0); end
    end
    Addr = 2'd3; #1; checks++;
    if (DataRd[15] !== 1'b0) begin errors++; $display("FAIL forced_off_ph got %b exp 0", DataRd[15]); end
  endtask

  task automatic test_reset_mid_blink;
    do_write(2'd2, 16'h0302);
    @(negedge Clk); @(negedge Clk); checks++;
    if (Led !== 6'b000001) begin errors++; $display("FAIL preblink got %b exp %b", Led, 6'b000001); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; checks++;
    if (Led !== 6'b0) begin errors++; $display("FAIL mid_rst_led got %b exp %b", Led, 6'b0); end
    Addr = 2'd0; #1; checks++;
    if (DataRd !== 16'h0000) begin errors++; $display("FAIL mid_rst_a0 got %h exp %h", DataRd, 16'h0000); end
    Addr = 2'd1; #1; checks++;
    if (DataRd !== 16'h0000) begin errors++; $display("FAIL mid_rst_a1 got %h exp %h", DataRd, 16'h0000); end
    Addr = 2'd2; #1; checks++;
    if (DataRd !== 16'h0808) begin errors++; $display("FAIL mid_rst_a2 got %h exp %h", DataRd, 16'h0808); end
  endtask

  task automatic test_wr_gating;
    do_write(2'd0, 16'h000A);
    @(negedge Clk);
    Addr = 2'd0; DataWr = 16'h0015; Wr = 1'b1; En = 1'b1; Reset = 1'b1;
    @(negedge Clk);
    Wr = 1'b0; En = 1'b0; Reset = 1'b0;
    #1; checks++;
    if (DataRd !== 16'h0000) begin errors++; $display("FAIL rst_wins got %h exp %h", DataRd, 16'h0000); end
    do_write(2'd0, 16'h000A);
    @(negedge Clk);
    Addr = 2'd0; DataWr = 16'h0015; Wr = 1'b1; En = 1'b0;
    @(negedge Clk);
    Wr = 1'b0;
    #1; checks++;
    if (DataRd !== 16'h000A) begin errors++; $display("FAIL en_gate got %h exp %h", DataRd, 16'h000A); end
    do_write(2'd3, 16'h1234);
    Addr = 2'd2; #1; checks++;
    if (DataRd !== 16'h0808) begin errors++; $display("FAIL a3_wr_a2 got %h exp %h", DataRd, 16'h0808); end
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim;
    int cnt;
    int exp_cnt [3];
    logic [15:0] duty [3];
    duty[0] = 16'd4;  exp_cnt[0] = 8;
    duty[1] = 16'd15; exp_cnt[1] = 32;
    duty[2] = 16'd0;  exp_cnt[2] = 0;
    do_write(2'd1, 16'h0000);
    do_write(2'd0, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      do_write(2'd3, duty[k]);
      Addr = 2'd3; #1; checks++;
      if (DataRd[14:0] !== duty[k][14:0]) begin
        errors++; $display("FAIL duty_rb%0d got %h exp %h", k, DataRd[14:0], duty[k][14:0]);
      end
      @(negedge Clk);
      cnt = 0;
      for (int j = 0; j < 32; j++) begin
        @(negedge Clk);
        if (Led[0] === 1'b1) cnt++;
      end
      checks++;
      if (cnt !== exp_cnt[k]) begin
        errors++; $display("FAIL dim%0d got %0d exp %0d", k, cnt, exp_cnt[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_led_val();
    test_blink();
    test_degenerate();
    test_reset_mid_blink();
    test_wr_gating();
`ifdef LED_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
